// File: rtl/kyber_pkg.sv
// Shared constants, widths and FSM encoding for the Kyber
// coefficient packer and its reduction helper.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int COEF_W  = 12;
    localparam int LANES   = 8;
    localparam int WORD_W  = COEF_W * LANES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mod_q_reduce.sv
// Single conditional subtraction of Q; flags inputs that were
// outside [0, Q) so the caller can track range violations.
module mod_q_reduce #(
    parameter int Q = kyber_pkg::KYBER_Q
) (
    input  logic [kyber_pkg::COEF_W-1:0] coef,
    output logic [kyber_pkg::COEF_W-1:0] res,
    output logic                         over
);
    import kyber_pkg::*;

    localparam logic [COEF_W-1:0] QW = COEF_W'(Q);

    // subtract Q once when the coefficient is at or above it
    always_comb begin
        over = (coef >= QW);
        res  = over ? (coef - QW) : coef;
    end

endmodule

// File: rtl/coef_packer.sv
// Packs a stream of 12-bit coefficients, reduced mod Q, into
// 96-bit RAM words of eight lanes each, one word per address.
module coef_packer #(
    parameter int NUM_WORDS = 256,
    parameter int KYBER_Q   = kyber_pkg::KYBER_Q
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         s_valid,
    input  logic [kyber_pkg::COEF_W-1:0] s_data,
    output logic                         s_ready,
    output logic                         wr_en,
    output logic [7:0]                   wr_addr,
    output logic [kyber_pkg::WORD_W-1:0] wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err_range
);
    import kyber_pkg::*;

    localparam logic [7:0] LAST_WORD = 8'(NUM_WORDS - 1);
    localparam logic [2:0] LAST_LANE = 3'(LANES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          lane;
    logic [7:0]          word;
    logic [WORD_W-1:0]   pack;
    logic [WORD_W-1:0]   pack_nxt;
    logic [COEF_W-1:0]   red;
    logic                over;
    logic                go;
    logic                accept;
    logic                last_lane;
    logic                last_word;

    mod_q_reduce #(
        .Q(KYBER_Q)
    ) u_reduce (
        .coef(s_data),
        .res (red),
        .over(over)
    );

    assign go        = (state == IDLE) && start;
    assign accept    = s_ready && s_valid;
    assign last_lane = (lane == LAST_LANE);
    assign last_word = (word == LAST_WORD);

    // drop the reduced coefficient into its lane of the word
    always_comb begin
        pack_nxt = pack;
        pack_nxt[int'(lane)*COEF_W +: COEF_W] = red;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (accept && last_lane && last_word) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // lane/word counters, packing register and RAM write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane      <= '0;
            word      <= '0;
            pack      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err_range <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (go) begin
                lane      <= '0;
                word      <= '0;
                pack      <= '0;
                err_range <= 1'b0;
            end else if (accept) begin
                pack <= pack_nxt;
                lane <= lane + 3'd1;
                if (over) err_range <= 1'b1;
                if (last_lane) begin
                    wr_en   <= 1'b1;
                    wr_addr <= word;
                    wr_data <= pack_nxt;
                    word    <= last_word ? 8'd0 : word + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_coef_packer.sv
// Table-driven and randomized bench for coef_packer against a
// list-based model of accepted coefficients grouped by eight.
module tb_coef_packer;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [11:0] s_data = '0;
    logic        s_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [95:0] wr_data;
    logic        busy;
    logic        done;
    logic        err_range;

    always #5 clk = ~clk;

    coef_packer #(
        .NUM_WORDS(256),
        .KYBER_Q  (Q)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err_range(err_range)
    );

    typedef struct packed {
        logic [95:0] cin;
        logic [95:0] exp;
        logic        err;
    } rec_t;

    rec_t tbl[5];

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;

    bit          m_loading = 1'b0;
    int          m_tail = 0;
    int          m_lane = 0;
    int          m_word = 0;
    bit          m_err = 1'b0;
    logic [11:0] m_cur[8];
    bit          exp_wr = 1'b0;
    logic [7:0]  exp_addr = '0;
    logic [95:0] exp_data = '0;
    logic [7:0]  last_addr = '0;
    logic [95:0] last_data = '0;
    logic [95:0] cap_data = '0;
    logic [7:0]  cap_addr = '0;

    function automatic logic [11:0] ref_red(input logic [11:0] c);
        if (int'(c) >= Q) return 12'(int'(c) - Q);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit st, input bit v, input logic [11:0] c);
        bit idle;
        bit acc;
        start   = st;
        s_valid = v;
        s_data  = c;
        @(posedge clk);
        idle   = !m_loading && (m_tail == 0);
        acc    = v && m_loading;
        exp_wr = 1'b0;
        if (m_tail > 0) m_tail--;
        if (st && idle) begin
            m_loading = 1'b1;
            m_lane    = 0;
            m_word    = 0;
            m_err     = 1'b0;
        end
        if (acc) begin
            m_cur[m_lane] = ref_red(c);
            if (int'(c) >= Q) m_err = 1'b1;
            m_lane++;
            if (m_lane == 8) begin
                exp_wr   = 1'b1;
                exp_addr = 8'(m_word);
                for (int k = 0; k < 8; k++) exp_data[12*k +: 12] = m_cur[k];
                m_lane = 0;
                m_word++;
                if (m_word == 256) begin
                    m_loading = 1'b0;
                    m_tail    = 2;
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("s_ready", 96'(s_ready), 96'(m_loading));
        chk("busy", 96'(busy), 96'(m_loading || m_tail == 2));
        chk("done", 96'(done), 96'(m_tail == 1));
        chk("err_range", 96'(err_range), 96'(m_err));
        chk("wr_en", 96'(wr_en), 96'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", 96'(wr_addr), 96'(exp_addr));
            chk("wr_data", wr_data, exp_data);
            last_addr = exp_addr;
            last_data = exp_data;
            cap_addr  = wr_addr;
            cap_data  = wr_data;
            n_wr++;
        end else begin
            chk("hold_addr", 96'(wr_addr), 96'(last_addr));
            chk("hold_data", wr_data, last_data);
        end
    endtask

    task automatic do_reset();
        start   = 1'b0;
        s_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_s_ready", 96'(s_ready), 96'(0));
        chk("rst_wr_en", 96'(wr_en), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_err", 96'(err_range), 96'(0));
        chk("rst_addr", 96'(wr_addr), 96'(0));
        chk("rst_data", wr_data, 96'(0));
        m_loading = 1'b0;
        m_tail    = 0;
        m_lane    = 0;
        m_word    = 0;
        m_err     = 1'b0;
        exp_wr    = 1'b0;
        last_addr = '0;
        last_data = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int wr0;
        bit st;

        tbl[0] = '{cin: {12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0},
                   exp: 96'h007006005004003002001000, err: 1'b0};
        tbl[1] = '{cin: {8{12'hD00}}, exp: {8{12'hD00}}, err: 1'b0};
        tbl[2] = '{cin: {48'h0, 12'hD02, 36'h0},
                   exp: {48'h0, 12'h001, 36'h0}, err: 1'b1};
        tbl[3] = '{cin: {8{12'hFFF}}, exp: {8{12'h2FE}}, err: 1'b1};
        tbl[4] = '{cin: {{7{12'd5}}, 12'd3329},
                   exp: {{7{12'd5}}, 12'd0}, err: 1'b1};

        @(negedge clk);
        do_reset();

        // one load: table words, toggled-valid word, then random fill
        step(1'b1, 1'b0, 12'd0);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 8; k++) step(1'b0, 1'b1, tbl[r].cin[12*k +: 12]);
            chk($sformatf("tbl%0d_addr", r), 96'(cap_addr), 96'(r));
            chk($sformatf("tbl%0d_word", r), cap_data, tbl[r].exp);
            chk($sformatf("tbl%0d_err", r), 96'(err_range), 96'(tbl[r].err));
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, tbl[0].cin[12*k +: 12]);
            step(1'b0, 1'b0, 12'hABC);
        end
        chk("toggle_addr", 96'(cap_addr), 96'(5));
        chk("toggle_word", cap_data, tbl[0].exp);

        for (int i = 0; i < 20000 && m_loading; i++) begin
            st = (m_word == 10) && (m_lane == 0 || m_lane == 3);
            step(st, ($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)));
        end
        chk("rand_load_ended", 96'(m_loading), 96'(0));
        step(1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b0, 12'd0);
        chk("err_sticky", 96'(err_range), 96'(1));

        // new start clears the sticky flag, then a clean full load
        step(1'b1, 1'b0, 12'd0);
        chk("err_cleared", 96'(err_range), 96'(0));
        wr0 = n_wr;
        for (int i = 0; i < 2048; i++) step(1'b0, 1'b1, 12'(i % 256));
        chk("flush_busy", 96'(busy), 96'(1));
        step(1'b0, 1'b0, 12'd0);
        chk("done_2cyc", 96'(done), 96'(1));
        step(1'b0, 1'b0, 12'd0);
        chk("done_1cyc", 96'(done), 96'(0));
        chk("busy_after", 96'(busy), 96'(0));
        chk("wr_count", 96'(n_wr - wr0), 96'(256));
        chk("last_addr", 96'(cap_addr), 96'(255));

        // reset in the middle of word 3 drops the partial word
        step(1'b1, 1'b0, 12'd0);
        for (int i = 0; i < 29; i++) step(1'b0, 1'b1, 12'(i + 100));
        wr0 = n_wr;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 12'd9);
        chk("no_wr_after_rst", 96'(n_wr - wr0), 96'(0));
        step(1'b1, 1'b0, 12'd0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, tbl[0].cin[12*k +: 12]);
        chk("fresh_addr", 96'(cap_addr), 96'(0));
        chk("fresh_word", cap_data, tbl[0].exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
